bn_param_loader: RTL and testbench

Loads and holds the per-neuron batch-normalization parameters (BN_factor, BN_addend) that the normalization datapath consumes.
- Accepts a byte-serial parameter stream over a valid/ready handshake.
- Validates each factor/addend pair against the legal encoding and sanitizes illegal pairs.
- Double-buffers the table so the neuron array always sees a coherent parameter set.
- Serves combinational per-neuron read ports to the neuron array.

---
 rtl/bn_param_loader.sv | 192 +++++++++++++++++++
 tb/tb_bn_param_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bn_param_loader.sv
// bn_param_loader: loads, validates and double-buffers per-neuron batch-norm
// parameters (BN_factor, BN_addend) from a byte-serial valid/ready stream.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load_start            pulse, begins a load when idle
//   abort                 pulse, discards an in-progress load
//   data_in/data_valid    stream word {factor[3:0], addend} and its valid
//   data_ready            loader accepts data_in this cycle
//   busy                  loader not idle
//   done                  one-cycle pulse when the shadow table is committed
//   param_error           sticky, an accepted word was sanitized
//   rd_index              read address into the active table
//   factor_out/addend_out active entry at rd_index (combinational)
//   checksum_error        sticky, trailing checksum word mismatched
//                         (only with BN_PARAM_CHECKSUM_EN defined)
//
// Optional feature macro: BN_PARAM_CHECKSUM_EN adds a CHECK state that accepts
// one extra word which must equal the XOR of all raw parameter words.
module bn_param_loader #(
    parameter int unsigned NEURONS      = 4,
    parameter int unsigned ADDEND_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load_start,
    input  logic                            abort,
    input  logic [4+ADDEND_WIDTH-1:0]       data_in,
    input  logic                            data_valid,
    output logic                            data_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            param_error,
    input  logic [$clog2(NEURONS)-1:0]      rd_index,
    output logic [3:0]                      factor_out,
    output logic [ADDEND_WIDTH-1:0]         addend_out
`ifdef BN_PARAM_CHECKSUM_EN
   ,output logic                            checksum_error
`endif
);

    localparam int unsigned IDX_W  = $clog2(NEURONS);
    localparam int unsigned DATA_W = 4 + ADDEND_WIDTH;
    localparam logic [3:0]  FACTOR_ONE = 4'b0100;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
`ifdef BN_PARAM_CHECKSUM_EN
       ,CHECK  = 2'd3
`endif
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [3:0]              shd_factor [NEURONS];
    logic [ADDEND_WIDTH-1:0] shd_addend [NEURONS];
    logic [3:0]              act_factor [NEURONS];
    logic [ADDEND_WIDTH-1:0] act_addend [NEURONS];
`ifdef BN_PARAM_CHECKSUM_EN
    logic [DATA_W-1:0]       csum;
`endif

    logic [3:0]              in_factor;
    logic [ADDEND_WIDTH-1:0] in_addend;
    logic                    word_legal;
    logic                    xfer;

    assign in_factor = data_in[DATA_W-1 -: 4];
    assign in_addend = data_in[ADDEND_WIDTH-1:0];
    assign xfer      = data_valid && data_ready;

    // Legal encoding check; x8 (0011) only allowed with a zero addend.
    always_comb begin
        word_legal = 1'b1;
        case (in_factor)
            4'b0000, 4'b0111, 4'b1011, 4'b1111: word_legal = 1'b0;
            4'b0011:                            word_legal = (in_addend == '0);
            default:                            word_legal = 1'b1;
        endcase
    end

    // Loader FSM with registered handshake/status outputs and both tables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            data_ready  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            param_error <= 1'b0;
            for (int unsigned i = 0; i < NEURONS; i++) begin
                shd_factor[i] <= FACTOR_ONE;
                shd_addend[i] <= '0;
                act_factor[i] <= FACTOR_ONE;
                act_addend[i] <= '0;
            end
`ifdef BN_PARAM_CHECKSUM_EN
            csum           <= '0;
            checksum_error <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state       <= LOAD;
                        idx         <= '0;
                        param_error <= 1'b0;
                        data_ready  <= 1'b1;
                        busy        <= 1'b1;
`ifdef BN_PARAM_CHECKSUM_EN
                        csum           <= '0;
                        checksum_error <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state      <= IDLE;
                        data_ready <= 1'b0;
                        busy       <= 1'b0;
                    end else if (xfer) begin
                        shd_factor[idx] <= word_legal ? in_factor : FACTOR_ONE;
                        shd_addend[idx] <= word_legal ? in_addend : '0;
                        if (!word_legal) begin
                            param_error <= 1'b1;
                        end
                        idx <= idx + IDX_W'(1);
`ifdef BN_PARAM_CHECKSUM_EN
                        csum <= csum ^ data_in;
                        if (idx == LAST_IDX) begin
                            state <= CHECK;
                        end
`else
                        if (idx == LAST_IDX) begin
                            state      <= COMMIT;
                            data_ready <= 1'b0;
                            done       <= 1'b1;
                        end
`endif
                    end
                end
`ifdef BN_PARAM_CHECKSUM_EN
                CHECK: begin
                    if (abort) begin
                        state      <= IDLE;
                        data_ready <= 1'b0;
                        busy       <= 1'b0;
                    end else if (xfer) begin
                        data_ready <= 1'b0;
                        if (data_in == csum) begin
                            state <= COMMIT;
                            done  <= 1'b1;
                        end else begin
                            state          <= IDLE;
                            busy           <= 1'b0;
                            checksum_error <= 1'b1;
                        end
                    end
                end
`endif
                COMMIT: begin
                    for (int unsigned i = 0; i < NEURONS; i++) begin
                        act_factor[i] <= shd_factor[i];
                        act_addend[i] <= shd_addend[i];
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    data_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Combinational read of the active table; out-of-range reads give x1/0.
    always_comb begin
        factor_out = FACTOR_ONE;
        addend_out = '0;
        if (32'(rd_index) < NEURONS) begin
            factor_out = act_factor[rd_index];
            addend_out = act_addend[rd_index];
        end
    end

endmodule

// File: tb/tb_bn_param_loader.sv
// Directed, table-driven bench for bn_param_loader (NEURONS=4, ADDEND_WIDTH=4).
module tb_bn_param_loader;

    localparam int N  = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic          busy;
    logic          done;
    logic          param_error;
    logic [1:0]    rd_index = 2'd0;
    logic [3:0]    factor_out;
    logic [AW-1:0] addend_out;
`ifdef BN_PARAM_CHECKSUM_EN
    logic          checksum_error;
`endif

    bn_param_loader #(.NEURONS(N), .ADDEND_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .abort       (abort),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .busy        (busy),
        .done        (done),
        .param_error (param_error),
        .rd_index    (rd_index),
        .factor_out  (factor_out),
        .addend_out  (addend_out)
`ifdef BN_PARAM_CHECKSUM_EN
       ,.checksum_error (checksum_error)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] words;  // {w3, w2, w1, w0}
        logic [15:0] f;      // expected factors {f3, f2, f1, f0}
        logic [15:0] a;      // expected addends {a3, a2, a1, a0}
        logic        err;
        logic        gap;
    } vec_t;

    vec_t        vt [4];
    int          n_vec = 0;
    int          n_bad = 0;
    int          hs_cnt = 0;
    logic [15:0] mf = 16'h4444;
    logic [15:0] ma = 16'h0000;

    always @(posedge clk) begin
        if (rst_n && data_valid && data_ready) hs_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_table(input string name, input logic [15:0] f, input logic [15:0] a);
        for (int i = 0; i < N; i++) begin
            rd_index = 2'(i);
            #1;
            chk({name, "_factor"}, 32'(factor_out), 32'(f[4*i +: 4]));
            chk({name, "_addend"}, 32'(addend_out), 32'(a[4*i +: 4]));
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("start_ready", 32'(data_ready), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_perr_clr", 32'(param_error), 32'd0);
`ifdef BN_PARAM_CHECKSUM_EN
        chk("start_cerr_clr", 32'(checksum_error), 32'd0);
`endif
    endtask

    // Full load; checks done timing, old table held during done, handshake count.
    task automatic run_load(input logic [31:0] words, input logic gap);
        int         h0;
        logic [7:0] cs;
        cs = 8'h00;
        start_load();
        h0 = hs_cnt;
        for (int i = 0; i < N; i++) begin
            if (gap) begin
                data_valid = 1'b0;
                @(negedge clk);
                chk("gap_ready", 32'(data_ready), 32'd1);
                chk("gap_no_done", 32'(done), 32'd0);
            end
            data_valid = 1'b1;
            data_in    = words[8*i +: 8];
            cs         = cs ^ data_in;
            @(negedge clk);
`ifdef BN_PARAM_CHECKSUM_EN
            chk("early_done", 32'(done), 32'd0);
`else
            if (i < N - 1) chk("early_done", 32'(done), 32'd0);
`endif
        end
`ifdef BN_PARAM_CHECKSUM_EN
        data_in = cs;
        @(negedge clk);
`endif
        data_valid = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_not_ready", 32'(data_ready), 32'd0);
        check_table("hold_old", mf, ma);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
`ifdef BN_PARAM_CHECKSUM_EN
        chk("handshakes", 32'(hs_cnt - h0), 32'(N + 1));
`else
        chk("handshakes", 32'(hs_cnt - h0), 32'(N));
`endif
    endtask

    // Start a load and push two words, leaving the FSM mid-load.
    task automatic partial_load();
        start_load();
        data_valid = 1'b1;
        data_in    = 8'h6A;
        @(negedge clk);
        data_in    = 8'h88;
        @(negedge clk);
    endtask

    initial begin
        vt[0] = '{words: 32'hC2301F41, f: 16'hC314, a: 16'h20F1, err: 1'b0, gap: 1'b0};
        vt[1] = '{words: 32'hF0317300, f: 16'h4444, a: 16'h0000, err: 1'b1, gap: 1'b0};
        vt[2] = '{words: 32'hC2301F41, f: 16'hC314, a: 16'h20F1, err: 1'b0, gap: 1'b1};
        vt[3] = '{words: 32'h6AB188E7, f: 16'h648E, a: 16'hA087, err: 1'b1, gap: 1'b0};

        // Reset state.
        @(negedge clk);
        chk("rst_ready", 32'(data_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_perr", 32'(param_error), 32'd0);
        check_table("rst", 16'h4444, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // abort and load_start behaviour in IDLE.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);

        for (int v = 0; v < 4; v++) begin
            run_load(vt[v].words, vt[v].gap);
            mf = vt[v].f;
            ma = vt[v].a;
            check_table("vec", mf, ma);
            chk("vec_perr", 32'(param_error), 32'(vt[v].err));
        end

        // Abort after two words; abort wins over a same-cycle transfer.
        partial_load();
        abort      = 1'b1;
        data_in    = 8'hC2;
        @(negedge clk);
        abort      = 1'b0;
        data_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(data_ready), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        check_table("abort_keep", mf, ma);

        // Full load after abort still works.
        run_load(vt[0].words, 1'b0);
        mf = vt[0].f;
        ma = vt[0].a;
        check_table("post_abort", mf, ma);

        // Reset in the middle of a load.
        partial_load();
        rst_n      = 1'b0;
        data_valid = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(data_ready), 32'd0);
        mf = 16'h4444;
        ma = 16'h0000;
        check_table("midrst", mf, ma);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle", 32'(busy), 32'd0);

`ifdef BN_PARAM_CHECKSUM_EN
        // Bad checksum: no commit, sticky error, cleared by next load_start.
        start_load();
        data_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            data_in = vt[0].words[8*i +: 8];
            @(negedge clk);
        end
        data_in = 8'hAD;
        @(negedge clk);
        data_valid = 1'b0;
        chk("cs_bad_done", 32'(done), 32'd0);
        chk("cs_bad_busy", 32'(busy), 32'd0);
        chk("cs_bad_err", 32'(checksum_error), 32'd1);
        @(negedge clk);
        chk("cs_bad_done2", 32'(done), 32'd0);
        check_table("cs_bad_keep", mf, ma);
        run_load(vt[0].words, 1'b0);
        mf = vt[0].f;
        ma = vt[0].a;
        check_table("cs_good", mf, ma);
        chk("cs_good_err", 32'(checksum_error), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
